// File: rtl/gam_edge_manager_pkg.sv
// Shared types and default sizes for the class-partitioned edge store.
package GAM_package;

  localparam int CLASS_COUNT_DEF = 4;
  localparam int NODE_COUNT_DEF  = 10;
  localparam int AGE_MAX_DEF     = 2;
  localparam int AGE_W_DEF       = 8;
  // Widest age a connection entry can hold; instances use the low AGE_W bits.
  localparam int CONN_AGE_W      = 16;

  typedef enum logic [2:0] {
    NOP, CONNECT, DISCONNECT, QUERY, AGE, REMOVE_NODE, CLEAR_CLASS
  } edge_op_T;

  typedef enum logic [1:0] {
    OK, ERR_RANGE, ERR_SELF
  } edge_status_T;

  typedef enum logic [2:0] {
    IDLE, EXEC, SWEEP_AGE, SWEEP_CLR, DONE
  } edge_fsm_T;

  typedef struct packed {
    logic                  present;
    logic [CONN_AGE_W-1:0] age;
  } conn_T;

endpackage

// File: rtl/gam_edge_manager.sv
// Per-class symmetric edge presence/age store with aging and node-removal sweeps.
module gam_edge_manager
  import GAM_package::*;
#(
  parameter  int CLASS_COUNT = CLASS_COUNT_DEF,
  parameter  int NODE_COUNT  = NODE_COUNT_DEF,
  parameter  int AGE_MAX     = AGE_MAX_DEF,
  parameter  int AGE_W       = AGE_W_DEF,
  localparam int CW          = $clog2(CLASS_COUNT + 1),
  localparam int NW          = $clog2(NODE_COUNT + 1)
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  edge_op_T         cmd_op,
  input  logic [CW-1:0]    cmd_class,
  input  logic [NW-1:0]    cmd_a,
  input  logic [NW-1:0]    cmd_b,
  output logic             rsp_valid,
  output edge_status_T     rsp_status,
  output logic             rsp_present,
  output logic [AGE_W-1:0] rsp_age,
  output logic [NW-1:0]    rsp_count
);

  localparam logic [CW-1:0]    CLASS_LAST = CW'(CLASS_COUNT);
  localparam logic [NW-1:0]    NODE_LAST  = NW'(NODE_COUNT);
  localparam logic [AGE_W-1:0] AGE_LIM    = AGE_W'(AGE_MAX);

  function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] a);
    return (a == '1) ? a : a + 1'b1;
  endfunction

  function automatic logic [NW-1:0] cnt_inc(input logic [NW-1:0] c);
    return (c >= NODE_LAST) ? NODE_LAST : c + 1'b1;
  endfunction

  conn_T mem [1:CLASS_COUNT][1:NODE_COUNT][1:NODE_COUNT];

  edge_fsm_T     state, state_nxt;
  logic          run_q;
  logic [CW-1:0] cls_q;
  logic [NW-1:0] a_q, j_q;
  logic          accept, cls_bad, a_bad, b_bad, range_err, self_err;
  conn_T         q_conn, s_conn, s_new, conn_fresh;
  logic [AGE_W-1:0] s_age;

  assign cmd_ready = run_q && (state == IDLE);
  assign rsp_valid = (state == EXEC) || (state == DONE);
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    cls_bad   = (cmd_class == '0) || (cmd_class > CLASS_LAST);
    a_bad     = (cmd_a == '0) || (cmd_a > NODE_LAST);
    b_bad     = (cmd_b == '0) || (cmd_b > NODE_LAST);
    range_err = 1'b0;
    self_err  = 1'b0;
    case (cmd_op)
      CONNECT, DISCONNECT: begin
        range_err = cls_bad || a_bad || b_bad;
        self_err  = (cmd_a == cmd_b);
      end
      QUERY:            range_err = cls_bad || a_bad || b_bad;
      AGE, REMOVE_NODE: range_err = cls_bad || a_bad;
      CLEAR_CLASS:      range_err = cls_bad;
      default:          range_err = 1'b0;
    endcase
  end

  // Read ports: command-addressed entry and the current sweep entry (a_q, j_q).
  always_comb begin
    q_conn     = mem[cmd_class][cmd_a][cmd_b];
    s_conn     = mem[cls_q][a_q][j_q];
    s_age      = age_inc(s_conn.age[AGE_W-1:0]);
    s_new      = '0;
    s_new.present = 1'b1;
    s_new.age[AGE_W-1:0] = s_age;
    conn_fresh = '0;
    conn_fresh.present = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      run_q <= 1'b0;
    end else begin
      state <= state_nxt;
      run_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) begin
        if (!range_err && cmd_op == AGE)              state_nxt = SWEEP_AGE;
        else if (!range_err && cmd_op == REMOVE_NODE) state_nxt = SWEEP_CLR;
        else                                          state_nxt = EXEC;
      end
      EXEC:                 state_nxt = IDLE;
      SWEEP_AGE, SWEEP_CLR: if (j_q == NODE_LAST) state_nxt = DONE;
      DONE:                 state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem         <= '{default: '0};
      cls_q       <= '0;
      a_q         <= '0;
      j_q         <= '0;
      rsp_status  <= OK;
      rsp_present <= 1'b0;
      rsp_age     <= '0;
      rsp_count   <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cls_q       <= cmd_class;
          a_q         <= cmd_a;
          j_q         <= NW'(1);
          rsp_status  <= OK;
          rsp_present <= 1'b0;
          rsp_age     <= '0;
          rsp_count   <= '0;
          if (range_err)     rsp_status <= ERR_RANGE;
          else if (self_err) rsp_status <= ERR_SELF;
          else begin
            case (cmd_op)
              CONNECT: begin
                mem[cmd_class][cmd_a][cmd_b] <= conn_fresh;
                mem[cmd_class][cmd_b][cmd_a] <= conn_fresh;
              end
              DISCONNECT: begin
                mem[cmd_class][cmd_a][cmd_b] <= '0;
                mem[cmd_class][cmd_b][cmd_a] <= '0;
                rsp_count <= {{(NW-1){1'b0}}, q_conn.present};
              end
              QUERY: begin
                rsp_present <= q_conn.present;
                rsp_age     <= q_conn.present ? q_conn.age[AGE_W-1:0] : '0;
              end
              CLEAR_CLASS: mem[cmd_class] <= '{default: '0};
              default: ;
            endcase
          end
        end
        // One neighbour j per cycle; both mirror entries are kept in step.
        SWEEP_AGE: begin
          j_q <= j_q + 1'b1;
          if (s_conn.present) begin
            if (s_age > AGE_LIM) begin
              mem[cls_q][a_q][j_q] <= '0;
              mem[cls_q][j_q][a_q] <= '0;
              rsp_count <= cnt_inc(rsp_count);
            end else begin
              mem[cls_q][a_q][j_q] <= s_new;
              mem[cls_q][j_q][a_q] <= s_new;
            end
          end
        end
        SWEEP_CLR: begin
          j_q <= j_q + 1'b1;
          if (s_conn.present) begin
            mem[cls_q][a_q][j_q] <= '0;
            mem[cls_q][j_q][a_q] <= '0;
            rsp_count <= cnt_inc(rsp_count);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gam_edge_manager.sv
// Directed bench for gam_edge_manager with hand-computed expectations.
module tb_gam_edge_manager;
  import GAM_package::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  edge_op_T     cmd_op;
  logic [2:0]   cmd_class;
  logic [3:0]   cmd_a, cmd_b;
  logic         rsp_valid;
  edge_status_T rsp_status;
  logic         rsp_present;
  logic [7:0]   rsp_age;
  logic [3:0]   rsp_count;

  int checks = 0;
  int errors = 0;

  gam_edge_manager dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_class(cmd_class), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_present(rsp_present),
    .rsp_age(rsp_age), .rsp_count(rsp_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  int st, pr, ag, cn, lt;

  // Called at a negedge; returns at the negedge where rsp_valid is seen.
  task automatic run_cmd(input edge_op_T op, input int cls, input int a, input int b);
    int guard;
    cmd_op = op;
    cmd_class = cls[2:0];
    cmd_a = a[3:0];
    cmd_b = b[3:0];
    cmd_valid = 1'b1;
    guard = 0;
    while (!cmd_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) check("ready_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lt = 1;
    while (!rsp_valid && lt < 40) begin
      @(negedge clk);
      lt++;
    end
    if (!rsp_valid) check("rsp_timeout", 0, 1);
    st = int'(rsp_status);
    pr = int'(rsp_present);
    ag = int'(rsp_age);
    cn = int'(rsp_count);
  endtask

  initial begin
    int w, pulses;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = NOP;
    cmd_class = '0;
    cmd_a = '0;
    cmd_b = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_status", rsp_status, OK);
    check("rst_present", rsp_present, 0);
    check("rst_age", rsp_age, 0);
    check("rst_count", rsp_count, 0);
    rst_n = 1'b1;
    #1 check("ready_before_edge", cmd_ready, 0);
    @(negedge clk);
    check("ready_after_release", cmd_ready, 1);

    run_cmd(CONNECT, 1, 2, 5);
    check("conn_status", st, OK);
    check("conn_lat", lt, 1);
    run_cmd(QUERY, 1, 5, 2);
    check("q_present", pr, 1);
    check("q_age", ag, 0);
    check("q_status", st, OK);

    run_cmd(AGE, 1, 2, 0);
    check("age1_count", cn, 0);
    check("age1_lat", lt, 11);
    run_cmd(QUERY, 1, 2, 5);
    check("age1_q_age", ag, 1);
    run_cmd(AGE, 1, 2, 0);
    check("age2_count", cn, 0);
    run_cmd(AGE, 1, 2, 0);
    check("age3_count", cn, 1);
    check("age3_lat", lt, 11);
    run_cmd(QUERY, 1, 5, 2);
    check("age3_q_present", pr, 0);
    check("age3_q_age", ag, 0);

    run_cmd(CONNECT, 1, 3, 4);
    run_cmd(CONNECT, 2, 3, 4);
    run_cmd(CONNECT, 2, 3, 7);
    run_cmd(REMOVE_NODE, 2, 3, 0);
    check("rmn_count", cn, 2);
    check("rmn_lat", lt, 11);
    run_cmd(QUERY, 2, 4, 3);
    check("rmn_q_c2", pr, 0);
    run_cmd(QUERY, 1, 4, 3);
    check("rmn_q_c1", pr, 1);

    run_cmd(CONNECT, 0, 1, 2);
    check("err_class0", st, ERR_RANGE);
    run_cmd(CONNECT, 1, 11, 2);
    check("err_node11", st, ERR_RANGE);
    run_cmd(CONNECT, 1, 4, 4);
    check("err_self", st, ERR_SELF);
    run_cmd(QUERY, 1, 11, 2);
    check("err_q_range", st, ERR_RANGE);
    run_cmd(QUERY, 1, 2, 1);
    check("err_no_change", pr, 0);
    run_cmd(QUERY, 1, 4, 4);
    check("err_self_no_change", pr, 0);

    run_cmd(DISCONNECT, 1, 4, 3);
    check("disc_count1", cn, 1);
    run_cmd(DISCONNECT, 1, 3, 4);
    check("disc_count0", cn, 0);
    run_cmd(NOP, 0, 0, 0);
    check("nop_status", st, OK);

    run_cmd(CONNECT, 3, 1, 2);
    run_cmd(CONNECT, 4, 1, 2);
    run_cmd(CLEAR_CLASS, 3, 9, 9);
    check("clr_status", st, OK);
    check("clr_count", cn, 0);
    check("clr_lat", lt, 1);
    run_cmd(QUERY, 3, 2, 1);
    check("clr_q_c3", pr, 0);
    run_cmd(QUERY, 4, 2, 1);
    check("clr_q_c4", pr, 1);

    // Command held valid across a sweep
    run_cmd(CONNECT, 1, 1, 2);
    cmd_op = AGE;
    cmd_class = 3'd1;
    cmd_a = 4'd1;
    cmd_b = 4'd0;
    cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    @(negedge clk);
    cmd_op = QUERY;
    cmd_b = 4'd2;
    w = 1;
    while (!cmd_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("hold_ready_wait", w, 12);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("hold_rsp_valid", rsp_valid, 1);
    check("hold_q_present", rsp_present, 1);
    check("hold_q_age", rsp_age, 1);
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    check("hold_single_accept", pulses, 0);

    // Reset in the middle of an AGE sweep
    run_cmd(CONNECT, 2, 5, 6);
    cmd_op = AGE;
    cmd_class = 3'd1;
    cmd_a = 4'd1;
    cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", cmd_ready, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_status", rsp_status, OK);
    check("mid_rst_present", rsp_present, 0);
    check("mid_rst_age", rsp_age, 0);
    check("mid_rst_count", rsp_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_ready_after", cmd_ready, 1);
    run_cmd(QUERY, 1, 2, 1);
    check("mid_rst_q_c1", pr, 0);
    run_cmd(QUERY, 2, 6, 5);
    check("mid_rst_q_c2", pr, 0);
    run_cmd(QUERY, 4, 1, 2);
    check("mid_rst_q_c4", pr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gam_edge_manager.md
GAM_EDGE_MANAGER -- requirements
Module: gam_edge_manager

Interface
REQ-001 SHALL have parameter CLASS_COUNT, default 4, number of classes; class ids 1..CLASS_COUNT.
REQ-002 SHALL have parameter NODE_COUNT, default 10, nodes per class; node ids 1..NODE_COUNT.
REQ-003 SHALL have parameter AGE_MAX, default 2, maximum age an edge survives.
REQ-004 SHALL have parameter AGE_W, default 8, age counter width; AGE_MAX < 2**AGE_W - 1.
REQ-005 SHALL have ports: clk input 1, the single clock; rst_n input 1, asynchronous active-low reset.
REQ-006 SHALL have ports: cmd_valid input 1, command offered; cmd_ready output 1, command accepted when both high.
REQ-007 SHALL have port: cmd_op input 3, opcode from edge_op_T: NOP, CONNECT, DISCONNECT, QUERY, AGE, REMOVE_NODE, CLEAR_CLASS.
REQ-008 SHALL have ports: cmd_class input CW, class id; cmd_a input NW, node a; cmd_b input NW, node b (CW/NW = $clog2(count+1)).
REQ-009 SHALL have ports: rsp_valid output 1, one-cycle pulse; rsp_status output 2, edge_status_T: OK, ERR_RANGE, ERR_SELF.
REQ-010 SHALL have ports: rsp_present output 1, QUERY result; rsp_age output AGE_W, QUERY age; rsp_count output NW, edges pruned/removed.

Function
REQ-011 Storage SHALL be a symmetric presence/age matrix per class; edge (a,b) is edge (b,a).
REQ-012 cmd_ready SHALL be high only in IDLE; commands are accepted only in IDLE.
REQ-013 Class 0, class > CLASS_COUNT, node 0, or node > NODE_COUNT SHALL give ERR_RANGE one cycle after acceptance, with no state change.
REQ-014 CONNECT and DISCONNECT with a==b SHALL give ERR_SELF with no state change.
REQ-015 CONNECT SHALL set presence=1 and age=0, whether the edge is new or existing; rsp one cycle after acceptance.
REQ-016 DISCONNECT SHALL clear presence and age; rsp one cycle after acceptance; rsp_count=1 if the edge was present, else 0.
REQ-017 QUERY SHALL return rsp_present and rsp_age of (a,b) one cycle after acceptance; rsp_age=0 when absent.
REQ-018 AGE(class,a) SHALL enter state SWEEP_AGE and visit j=1..NODE_COUNT, one j per cycle.
REQ-019 For each present edge (a,j) in SWEEP_AGE: age SHALL be incremented (saturating at 2**AGE_W-1); if the new age > AGE_MAX, the edge SHALL be removed and counted.
REQ-020 After the j=NODE_COUNT cycle, the block SHALL go to DONE, pulse rsp_valid with rsp_count, then return to IDLE; AGE latency is NODE_COUNT+1 cycles after acceptance.
REQ-021 REMOVE_NODE(class,a) SHALL use state SWEEP_CLR and sweep j=1..NODE_COUNT, clearing every (a,j) edge; rsp_count = edges removed; same latency as AGE.
REQ-022 CLEAR_CLASS(class) SHALL clear all edges of the class in one cycle; rsp one cycle after acceptance; rsp_count=0; cmd_a and cmd_b are ignored.
REQ-023 NOP SHALL be accepted and SHALL give status OK with no state change.
REQ-024 Edges of other classes SHALL never be modified by any command.
REQ-025 The FSM SHALL have states IDLE, EXEC, SWEEP_AGE, SWEEP_CLR, DONE; single-cycle ops go IDLE->EXEC->IDLE, with rsp_valid in EXEC.
REQ-026 rsp_count SHALL saturate at NODE_COUNT.

Reset
REQ-027 Asserting rst_n low at any time, including mid-sweep, SHALL force IDLE and clear all presence bits and ages.
REQ-028 During reset: cmd_ready=0, rsp_valid=0, rsp_status=OK, rsp_present=0, rsp_age=0, rsp_count=0.
REQ-029 cmd_ready SHALL rise on the first clk edge after rst_n deasserts.

Structure
REQ-030 edge_op_T, edge_status_T, CLASS_COUNT, NODE_COUNT and AGE_MAX defaults SHALL live in GAM_package.
REQ-031 Storage SHALL reuse the package connection structure, indexed [class][node][node] with 1-based ranges.
REQ-032 A single module SHALL be used, with no sub-module.

Verification
REQ-033 CONNECT(1,2,5), then QUERY(1,5,2) -> present=1, age=0, OK.
REQ-034 CONNECT(1,2,5); then AGE(1,2) three times -> rsp_count 0, 0, 1 (AGE_MAX=2); QUERY -> present=0; each AGE response arrives 11 cycles after acceptance.
REQ-035 CONNECT(2,3,4) and CONNECT(2,3,7); REMOVE_NODE(2,3) -> rsp_count=2; class 1 edges unchanged.
REQ-036 CONNECT(0,1,2) -> ERR_RANGE; CONNECT(1,11,2) -> ERR_RANGE; CONNECT(1,4,4) -> ERR_SELF; no state change in any case.
REQ-037 Assert rst_n low during cycle 5 of an AGE sweep -> all edges cleared, outputs at reset values, cmd_ready=1 one cycle after release.
REQ-038 Hold cmd_valid high during a sweep -> cmd_ready stays 0 until IDLE; the command is accepted exactly once afterwards.
